// File: rtl/pipeline_hazard_control.sv
// Hazard sequencer for the IF/ID and ID/EX registers: load-use stalls, redirect flushes,
// data-memory freeze, plus saturating stall/flush performance counters.
module pipeline_hazard_control #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_addr1,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_addr2,
    input  logic                      id_uses_rs2,
    input  logic                      ex_mem_rd_en,
    input  logic                      ex_reg_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr,
    input  logic                      ex_branch_taken,
    input  logic                      ex_jump_inst,
    input  logic                      mem_busy,
    input  logic                      cnt_clr,
    output logic                      pc_write_en,
    output logic                      pc_redirect,
    output logic                      if_id_write_en,
    output logic                      if_id_flush,
    output logic                      id_ex_write_en,
    output logic                      id_ex_bubble,
    output logic [CNT_WIDTH-1:0]      stall_count,
    output logic [CNT_WIDTH-1:0]      flush_count
);

    localparam int FL_W = ($clog2(FLUSH_CYCLES + 1) < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_FLUSH    = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t          state, state_nx;
    state_t          ret_state, ret_nx;
    state_t          eff_state;
    logic [FL_W-1:0] flush_left, left_nx;
    logic            load_use;
    logic            redirect;
    logic            stall_inc;
    logic            flush_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}})
            return v;
        return v + CNT_WIDTH'(1);
    endfunction

    // Register 0 is hard-wired to zero, so a load targeting it can never create a hazard.
    assign load_use = ex_mem_rd_en & ex_reg_wr_en & (ex_reg_wr_addr != '0) &
                      ((ex_reg_wr_addr == id_read_addr1) |
                       (id_uses_rs2 & (ex_reg_wr_addr == id_read_addr2)));
    assign redirect = ex_branch_taken | ex_jump_inst;

    // Leaving MEM_WAIT behaves exactly as the state that was frozen.
    assign eff_state = (state == S_MEM_WAIT) ? ret_state : state;

    always_comb begin
        pc_write_en    = 1'b0;
        pc_redirect    = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_write_en = 1'b0;
        id_ex_bubble   = 1'b0;
        state_nx       = state;
        ret_nx         = ret_state;
        left_nx        = flush_left;
        flush_inc      = 1'b0;

        if (rst) begin
            state_nx = S_RUN;
        end else if (mem_busy) begin
            state_nx = S_MEM_WAIT;
            if (state != S_MEM_WAIT)
                ret_nx = state;
        end else if (redirect) begin
            pc_write_en    = 1'b1;
            pc_redirect    = 1'b1;
            if_id_write_en = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_write_en = 1'b1;
            id_ex_bubble   = 1'b1;
            flush_inc      = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nx = S_FLUSH;
                left_nx  = FL_W'(FLUSH_CYCLES - 1);
            end else begin
                state_nx = S_RUN;
            end
        end else if (eff_state == S_FLUSH) begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_write_en = 1'b1;
            id_ex_bubble   = 1'b1;
            left_nx        = flush_left - FL_W'(1);
            state_nx       = (flush_left == FL_W'(1)) ? S_RUN : S_FLUSH;
        end else if (load_use) begin
            id_ex_write_en = 1'b1;
            id_ex_bubble   = 1'b1;
            state_nx       = S_RUN;
        end else begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            id_ex_write_en = 1'b1;
            state_nx       = S_RUN;
        end
    end

    assign stall_inc = ~rst & ~pc_write_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            ret_state   <= S_RUN;
            flush_left  <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state      <= state_nx;
            ret_state  <= ret_nx;
            flush_left <= left_nx;
            if (cnt_clr) begin
                stall_count <= '0;
                flush_count <= '0;
            end else begin
                if (stall_inc)
                    stall_count <= sat_inc(stall_count);
                if (flush_inc)
                    flush_count <= sat_inc(flush_count);
            end
        end
    end

endmodule
